// File: rtl/wb_stage.sv
// Writeback stage: one-entry holding register, load extraction, retire counter and sticky
// misalignment flag. Define WB_FWD_EN to expose the decode-stage bypass ports.
module wb_stage #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write,
  input  logic [1:0]           in_wb_sel,
  input  logic [2:0]           in_funct3,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_mem_rdata,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_imm,
  input  logic                 stall,
  output logic                 RegWriteEn,
  output logic [4:0]           rd,
  output logic [31:0]          data,
  output logic                 retire_valid,
  output logic [INSTRET_W-1:0] instret,
`ifdef WB_FWD_EN
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
`endif
  output logic                 misalign_err
);

  logic                 full_q, full_d;
  logic [4:0]           rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic [1:0]           wb_sel_q, wb_sel_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [31:0]          alu_q, alu_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          imm_q, imm_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 misalign_q, misalign_d;

  logic        commit;
  logic        capture;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign in_ready = !full_q || !stall;
  assign capture  = in_valid && in_ready;
  assign commit   = full_q && !stall;

  assign misaligned = (wb_sel_q == 2'b01) &&
                      (((funct3_q[1:0] == 2'b01) && alu_q[0]) ||
                       ((funct3_q == 3'b010) && (alu_q[1:0] != 2'b00)));

  always_comb begin
    ld_byte = rdata_q[7:0];
    unique case (alu_q[1:0])
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (funct3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = rdata_q;
    endcase
  end

  always_comb begin
    unique case (wb_sel_q)
      2'b00:   data = alu_q;
      2'b01:   data = ld_val;
      2'b10:   data = pc_q + 32'd4;
      default: data = imm_q;
    endcase
  end

  assign rd           = rd_q;
  assign retire_valid = commit;
  assign RegWriteEn   = commit && reg_write_q && (rd_q != 5'd0) && !misaligned;
  assign instret      = instret_q;
  assign misalign_err = misalign_q;

`ifdef WB_FWD_EN
  // Bypass ignores stall: the held value is already final while waiting to commit.
  assign fwd_valid = full_q && reg_write_q && (rd_q != 5'd0) && !misaligned;
  assign fwd_rd    = rd_q;
  assign fwd_data  = data;
`endif

  always_comb begin
    full_d      = full_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    instret_d   = instret_q;
    misalign_d  = misalign_q;
    if (commit) begin
      full_d    = 1'b0;
      instret_d = instret_q + 1'b1;
      if (misaligned) misalign_d = 1'b1;
    end
    if (capture) begin
      full_d      = 1'b1;
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
      wb_sel_d    = in_wb_sel;
      funct3_d    = in_funct3;
      alu_d       = in_alu_result;
      rdata_d     = in_mem_rdata;
      pc_d        = in_pc;
      imm_d       = in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q      <= 1'b0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 2'b00;
      funct3_q    <= 3'b000;
      alu_q       <= 32'd0;
      rdata_q     <= 32'd0;
      pc_q        <= 32'd0;
      imm_q       <= 32'd0;
      instret_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      instret_q   <= instret_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected commits are queued at capture and compared while held.
module tb_wb_stage;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rd;
  logic          in_reg_write;
  logic [1:0]    in_wb_sel;
  logic [2:0]    in_funct3;
  logic [31:0]   in_alu_result;
  logic [31:0]   in_mem_rdata;
  logic [31:0]   in_pc;
  logic [31:0]   in_imm;
  logic          stall;
  logic          RegWriteEn;
  logic [4:0]    rd;
  logic [31:0]   data;
  logic          retire_valid;
  logic [IW-1:0] instret;
  logic          misalign_err;

  wb_stage #(.INSTRET_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_alu_result(in_alu_result),
    .in_mem_rdata (in_mem_rdata),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .stall        (stall),
    .RegWriteEn   (RegWriteEn),
    .rd           (rd),
    .data         (data),
    .retire_valid (retire_valid),
    .instret      (instret),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } ent_t;

  ent_t          sb[$];
  logic          m_full = 1'b0;
  logic [IW-1:0] m_instret = '0;
  logic          m_mis = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] w,
                                           input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hff;
    h = (w >> (16 * a[1])) & 32'hffff;
    case (sel)
      2'd0: return a;
      2'd2: return pc + 32'd4;
      2'd3: return imm;
      default: begin
        if (f3 == 3'd0) return b[7] ? (b | 32'hffffff00) : b;
        if (f3 == 3'd4) return b;
        if (f3 == 3'd1) return h[15] ? (h | 32'hffff0000) : h;
        if (f3 == 3'd5) return h;
        return w;
      end
    endcase
  endfunction

  // One cycle: check outputs mid-cycle, then advance the model on the rising edge.
  task automatic tick();
    logic commit, cap;
    ent_t e;
    @(negedge clk);
    commit = m_full && !stall;
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_full || !stall});
    check("retire_valid", {31'd0, retire_valid}, {31'd0, commit});
    check("RegWriteEn", {31'd0, RegWriteEn}, {31'd0, commit && m_full && sb[0].we});
    if (m_full) begin
      check("rd", {27'd0, rd}, {27'd0, sb[0].rd});
      if (!sb[0].mis) check("data", data, sb[0].data);
    end
    check("instret", {{(32 - IW){1'b0}}, instret}, {{(32 - IW){1'b0}}, m_instret});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    @(posedge clk);
    if (!rst) begin
      sb.delete();
      m_full = 1'b0;
      m_instret = '0;
      m_mis = 1'b0;
    end else begin
      cap = in_valid && (!m_full || !stall);
      if (commit) begin
        e = sb.pop_front();
        m_instret = m_instret + 1'b1;
        if (e.mis) m_mis = 1'b1;
        m_full = 1'b0;
      end
      if (cap) begin
        e.mis = (in_wb_sel == 2'd1) &&
                (((in_funct3 == 3'd1 || in_funct3 == 3'd5) && in_alu_result[0]) ||
                 (in_funct3 == 3'd2 && in_alu_result[1:0] != 2'd0));
        e.rd   = in_rd;
        e.we   = in_reg_write && in_rd != 5'd0 && !e.mis;
        e.data = exp_data(in_wb_sel, in_funct3, in_alu_result, in_mem_rdata, in_pc, in_imm);
        sb.push_back(e);
        m_full = 1'b1;
      end
    end
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] w,
                       input logic [31:0] pc, input logic [31:0] imm);
    in_valid      = 1'b1;
    in_rd         = r;
    in_reg_write  = we;
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_alu_result = alu;
    in_mem_rdata  = w;
    in_pc         = pc;
    in_imm        = imm;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    in_valid = 1'b1;
    in_rd = 5'd7;
    in_reg_write = 1'b1;
    in_wb_sel = 2'd0;
    in_funct3 = 3'd0;
    in_alu_result = 32'hdead;
    in_mem_rdata = 32'd0;
    in_pc = 32'd0;
    in_imm = 32'd0;
    // reset held for two edges while in_valid is high
    tick();
    tick();
    rst = 1'b1;

    issue(5'd5, 1'b1, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
    issue(5'd6, 1'b1, 2'd1, 3'd0, 32'h103, 32'h80FF7F01, 32'h0, 32'h0);
    issue(5'd7, 1'b1, 2'd1, 3'd5, 32'h102, 32'h80FF7F01, 32'h0, 32'h0);
    issue(5'd8, 1'b1, 2'd1, 3'd1, 32'h100, 32'h80FF8001, 32'h0, 32'h0);
    issue(5'd9, 1'b1, 2'd1, 3'd4, 32'h101, 32'h80FF8001, 32'h0, 32'h0);
    issue(5'd0, 1'b1, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    issue(5'd1, 1'b1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h40, 32'h0);
    issue(5'd2, 1'b1, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'hABCDE000);
    issue(5'd3, 1'b0, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
    idle();

    // stall three cycles with an entry held and a new instruction waiting
    issue(5'd10, 1'b1, 2'd0, 3'd0, 32'hCAFE, 32'h0, 32'h0, 32'h0);
    stall = 1'b1;
    issue(5'd11, 1'b1, 2'd0, 3'd0, 32'hBEEF, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    stall = 1'b0;
    tick();
    idle();
    idle();

    // back-to-back burst, long enough to wrap the narrow counter
    for (int i = 0; i < 20; i++) begin
      issue(5'($urandom_range(1, 31)), 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            {$urandom} & 32'hFFFF_FFF0, $urandom, $urandom, $urandom);
    end
    idle();

    // misaligned loads; the sticky flag must survive later good instructions
    issue(5'd12, 1'b1, 2'd1, 3'd2, 32'h102, 32'h11223344, 32'h0, 32'h0);
    issue(5'd13, 1'b1, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0);
    issue(5'd14, 1'b1, 2'd1, 3'd1, 32'h201, 32'h11223344, 32'h0, 32'h0);
    issue(5'd15, 1'b1, 2'd1, 3'd2, 32'h200, 32'h11223344, 32'h0, 32'h0);
    idle();
    idle();

    // reset while an entry is pending: discarded without a write
    stall = 1'b1;
    issue(5'd16, 1'b1, 2'd0, 3'd0, 32'h4242, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stall = 1'b0;
    idle();
    idle();
    issue(5'd17, 1'b1, 2'd0, 3'd0, 32'h600D, 32'h0, 32'h0, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter INSTRET_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  MEM stage presents an instruction.
REQ-005 in_ready  output  1  stage accepts the presented instruction this cycle.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_reg_write  input  1  instruction writes a register.
REQ-008 in_wb_sel  input  2  result source: 00 ALU, 01 memory load, 10 PC+4, 11 immediate.
REQ-009 in_funct3  input  3  load size/sign code (RV32I encoding).
REQ-010 in_alu_result  input  32  ALU result; for loads, the byte address.
REQ-011 in_mem_rdata  input  32  aligned 32-bit word read from data memory.
REQ-012 in_pc  input  32  instruction PC.
REQ-013 in_imm  input  32  immediate (LUI value).
REQ-014 stall  input  1  hold the pending instruction; no commit this cycle.
REQ-015 RegWriteEn  output  1  register-file write enable.
REQ-016 rd  output  5  register-file write index.
REQ-017 data  output  32  register-file write data.
REQ-018 retire_valid  output  1  one instruction retires this cycle.
REQ-019 instret  output  INSTRET_W  count of retired instructions.
REQ-020 misalign_err  output  1  sticky misaligned-load flag.

Function
REQ-021 Stage SHALL hold one entry (full flag plus captured fields); capture occurs on the edge where in_valid && in_ready.
REQ-022 in_ready SHALL equal !full || !stall; simultaneous commit and capture SHALL allow back-to-back throughput of one instruction per cycle.
REQ-023 Commit SHALL occur in any cycle with full && !stall; retire_valid SHALL equal that condition, combinationally from registered state and stall.
REQ-024 Latency: an instruction captured on edge N SHALL drive RegWriteEn/rd/data in the cycle after edge N (if not stalled) so the register file writes on edge N+1.
REQ-025 RegWriteEn SHALL be commit && reg_write && rd!=0 && !misaligned; writes to x0 SHALL never be issued.
REQ-026 rd and data SHALL reflect the held entry whenever full; they are don't-care when !full.
REQ-027 data for wb_sel 00 = alu_result; 10 = pc+4 (mod 2^32); 11 = imm; 01 = extracted load value.
REQ-028 Load extraction by funct3: 000 LB, byte at addr[1:0], sign-extended; 100 LBU, zero-extended; 001 LH, halfword at addr[1], sign-extended; 101 LHU, zero-extended; 010 LW, full word; other codes, full word.
REQ-029 Misaligned = wb_sel 01 and ((LH/LHU and addr[0]) or (LW and addr[1:0]!=0)); a misaligned load SHALL retire with no register write and SHALL set misalign_err at the commit edge.
REQ-030 misalign_err SHALL remain set until reset.
REQ-031 instret SHALL increment by 1 at each commit edge, wrapping from all-ones to 0.
REQ-032 With stall asserted and full, all captured fields SHALL hold unchanged and in_ready SHALL be 0.

Reset
REQ-033 On a clock edge with rst=0: full=0, instret=0, misalign_err=0; RegWriteEn=0, retire_valid=0, in_ready=1 in the following cycle.
REQ-034 Reset asserted while an entry is pending SHALL discard it without a register write; inputs are ignored during reset.

Configuration
REQ-035 Macro WB_FWD_EN defined: outputs fwd_valid (1), fwd_rd (5), fwd_data (32) SHALL be present; fwd_valid = full && reg_write && rd!=0 && !misaligned, independent of stall; fwd_rd = rd, fwd_data = data, enabling decode-stage bypass.
REQ-036 Macro WB_FWD_EN undefined: those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset: rst=0 for 2 edges with in_valid=1 -> RegWriteEn=0, instret=0, misalign_err=0, in_ready=1.
REQ-038 ALU writeback: in_rd=5, wb_sel=00, alu_result=0x1234 -> next cycle RegWriteEn=1, rd=5, data=0x00001234; instret becomes 1.
REQ-039 LB at addr 0x103, mem_rdata=0x80FF7F01 -> data=0xFFFFFF80; LHU at 0x102 -> data=0x000080FF.
REQ-040 x0 and JAL: in_rd=0, wb_sel=00 -> RegWriteEn=0, retire_valid=1; in_rd=1, wb_sel=10, pc=0x40 -> data=0x44.
REQ-041 Stall 3 cycles with entry pending -> in_ready=0, RegWriteEn=0, fields held; release -> single write, instret +1.
REQ-042 LW at addr 0x102 -> RegWriteEn=0, retire_valid=1, misalign_err=1 and held through later valid instructions until reset.
